dispatch_ctrl: RTL

2-wide in-order dispatch controller between decode and the ROB/RS/map-table/free-list group. Buffers decoded instructions in a small FIFO and, each cycle, issues 0, 1 or 2 dispatch enables sized to ROB space, free-list registers and RS entries. Sequences branch-mispredict recovery: flush, hold-off, resume.

---
 rtl/dispatch_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: 2-wide in-order dispatch from a small instruction buffer with mispredict flush/recover sequencing
// Ports: clk/reset (async active-low); dec_* decoded pair in, dec_stall_o back-pressure;
// rob_status_i/fl_avail_i/rs_avail_i downstream capacity; branch_recover_i squash pulse;
// dispatch_en_o/dispatch_areg_o/fl_pop_o per-slot dispatch; ibuf_count_o occupancy; state_o FSM state.
`ifndef ARCHREG_NUMBER
`define ARCHREG_NUMBER 32
`endif
module dispatch_ctrl #(
  parameter int IBUF_DEPTH = 4,
  parameter int RECOVER_CYCLES = 2,
  parameter int AREG_W = $clog2(`ARCHREG_NUMBER)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       dec_valid_i,
  input  logic [1:0][AREG_W-1:0]           dec_dest_areg_i,
  input  logic [1:0]                       dec_has_dest_i,
  output logic                             dec_stall_o,
  input  logic [1:0]                       rob_status_i,
  input  logic [1:0]                       fl_avail_i,
  input  logic [1:0]                       rs_avail_i,
  input  logic                             branch_recover_i,
  output logic [1:0]                       dispatch_en_o,
  output logic [1:0][AREG_W-1:0]           dispatch_areg_o,
  output logic [1:0]                       fl_pop_o,
  output logic [$clog2(IBUF_DEPTH+1)-1:0]  ibuf_count_o,
  output logic [1:0]                       state_o
);
  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  localparam logic [1:0] ROB_FULL = 2'd0, ROB_ONE_LEFT = 2'd1;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, RECOVER = 2'd2} state_t;
  state_t state;
  logic [PW-1:0] head, tail, head1, tail1;
  logic [CW-1:0] count, enq, deq;
  logic [RW-1:0] rcnt;
  logic [AREG_W-1:0] areg_mem [IBUF_DEPTH];
  logic [IBUF_DEPTH-1:0] dest_mem;
  logic [1:0] rob_cap, dest_sum;
  logic run, enq0, enq1, d0, d1;
  assign head1 = head + PW'(1);
  assign tail1 = tail + PW'(1);
  assign run = state == RUN && !branch_recover_i;
  // stall looks only at registers; two free entries are always reserved for a full pair
  assign dec_stall_o = state != RUN || count > CW'(IBUF_DEPTH - 2);
  assign enq0 = !dec_stall_o && !branch_recover_i && dec_valid_i[0];
  assign enq1 = enq0 && dec_valid_i[1];
  assign rob_cap = rob_status_i == ROB_FULL ? 2'd0 : rob_status_i == ROB_ONE_LEFT ? 2'd1 : 2'd2;
  assign dest_sum = {1'b0, dest_mem[head]} + {1'b0, dest_mem[head1]};
  assign d0 = run && count >= CW'(1) && rob_cap >= 2'd1 && rs_avail_i >= 2'd1 &&
              (!dest_mem[head] || fl_avail_i >= 2'd1);
  // slot 1 only ever rides along with slot 0 to keep dispatch in order
  assign d1 = d0 && count >= CW'(2) && rob_cap >= 2'd2 && rs_avail_i >= 2'd2 && dest_sum <= fl_avail_i;
  assign enq = CW'(enq0) + CW'(enq1);
  assign deq = CW'(d0) + CW'(d1);
  assign dispatch_en_o = {d1, d0};
  assign fl_pop_o = {d1 & dest_mem[head1], d0 & dest_mem[head]};
  assign dispatch_areg_o[0] = d0 ? areg_mem[head] : '0;
  assign dispatch_areg_o[1] = d1 ? areg_mem[head1] : '0;
  assign ibuf_count_o = count;
  assign state_o = state;
  always_ff @(posedge clk) begin
    if (enq0) begin
      areg_mem[tail] <= dec_dest_areg_i[0];
      dest_mem[tail] <= dec_has_dest_i[0];
    end
    if (enq1) begin
      areg_mem[tail1] <= dec_dest_areg_i[1];
      dest_mem[tail1] <= dec_has_dest_i[1];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rcnt  <= '0;
    end else begin
      if (branch_recover_i) state <= FLUSH;
      else if (state == FLUSH) begin
        state <= RECOVER;
        rcnt  <= RW'(RECOVER_CYCLES - 1);
      end else if (state == RECOVER) begin
        if (rcnt == '0) state <= RUN;
        else rcnt <= rcnt - RW'(1);
      end
      if (state == FLUSH) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        head  <= head + PW'(deq);
        tail  <= tail + PW'(enq);
        count <= count + enq - deq;
      end
    end
endmodule
